// File: rtl/sccb_pkg.sv
// Shared constants for the SCCB responder: state encodings, ACK levels and byte width.
package sccb_pkg;

  localparam int unsigned ByteW = 8;

  // Level a receiver places on SDA during the ninth bit.
  localparam logic SCCB_ACK  = 1'b0;
  localparam logic SCCB_NACK = 1'b1;

  // Responder FSM state encodings.
  typedef logic [3:0] sccb_state_t;
  localparam sccb_state_t StIdle     = 4'd0;
  localparam sccb_state_t StDevAddr  = 4'd1;
  localparam sccb_state_t StDevAck   = 4'd2;
  localparam sccb_state_t StSubAddr  = 4'd3;
  localparam sccb_state_t StSubAck   = 4'd4;
  localparam sccb_state_t StWData    = 4'd5;
  localparam sccb_state_t StWDataAck = 4'd6;
  localparam sccb_state_t StRData    = 4'd7;
  localparam sccb_state_t StRdAck    = 4'd8;
  localparam sccb_state_t StIgnore   = 4'd9;

endpackage

// File: rtl/sccb_slave_regfile_if.sv
// Fabric-side view of the SCCB register file: read port plus write notification.
interface sccb_slave_regfile_if;
  import sccb_pkg::*;

  logic [ByteW-1:0] host_raddr;
  logic [ByteW-1:0] host_rdata;
  logic             wr_stb;
  logic [ByteW-1:0] wr_addr;
  logic [ByteW-1:0] wr_data;
  logic             busy;

  modport slave (
    input  host_raddr,
    output host_rdata,
    output wr_stb,
    output wr_addr,
    output wr_data,
    output busy
  );

  modport master (
    output host_raddr,
    input  host_rdata,
    input  wr_stb,
    input  wr_addr,
    input  wr_data,
    input  busy
  );

endinterface

// File: rtl/sccb_bus_sync.sv
// Synchronises SCL/SDA into the system clock and flags START, STOP and SCL edges.
// Events are registered, so they appear SyncStages+1 cycles after the pin change.
module sccb_bus_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SyncStages-1:0] scl_sync_q, scl_sync_d;
  logic [SyncStages-1:0] sda_sync_q, sda_sync_d;
  logic scl_cur, sda_cur;
  logic scl_hist_q, sda_hist_q;
  logic sda_q, sda_d;
  logic rise_q, rise_d, fall_q, fall_d, start_q, start_d, stop_q, stop_d;

  assign scl_cur = scl_sync_q[SyncStages-1];
  assign sda_cur = sda_sync_q[SyncStages-1];

  // Shift the pins through the synchroniser and decode edges against the history flop.
  always_comb begin
    scl_sync_d = {scl_sync_q[SyncStages-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SyncStages-2:0], sda_i};
    sda_d      = sda_cur;
    rise_d     = scl_cur & ~scl_hist_q;
    fall_d     = ~scl_cur & scl_hist_q;
    // SDA transitions only count as conditions when SCL is high on both samples.
    start_d    = scl_cur & scl_hist_q & sda_hist_q & ~sda_cur;
    stop_d     = scl_cur & scl_hist_q & ~sda_hist_q & sda_cur;
  end

  // Reset to the idle-bus level (both lines high) so no false event follows reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      sda_q      <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_cur;
      sda_hist_q <= sda_cur;
      sda_q      <= sda_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign sda_o      = sda_q;
  assign scl_rise_o = rise_q;
  assign scl_fall_o = fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/sccb_slave_regfile.sv
// SCCB/I2C target exposing a 256x8 register file, with a fabric read port and
// a write-notification strobe for every byte written from the bus.
module sccb_slave_regfile
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR    = 8'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 I2C_SCLK,
  inout  wire                  I2C_SDAT,
  sccb_slave_regfile_if.slave  host
);

  logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

  sccb_bus_sync #(
    .SyncStages (SYNC_STAGES)
  ) u_sync (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .scl_i      (I2C_SCLK),
    .sda_i      (I2C_SDAT),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (bus_start),
    .stop_o     (bus_stop)
  );

  sccb_state_t      state_q, state_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [ByteW-1:0] shift_q, shift_d;
  logic [ByteW-1:0] ptr_q, ptr_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             rw_q, rw_d;
  logic             wr_stb_q, wr_stb_d;
  logic [ByteW-1:0] wr_addr_q, wr_addr_d;
  logic [ByteW-1:0] wr_data_q, wr_data_d;
  logic [ByteW-1:0] host_rdata_q;
  logic [ByteW-1:0] bus_rdata_q;
  logic             mem_we;
  logic [ByteW-1:0] byte_in;

  logic [ByteW-1:0] regfile [256];

  // Open-drain: only ever pull low.
  assign I2C_SDAT = oe_q ? 1'b0 : 1'bz;

  // Bus FSM: bit sampling on SCL rise, SDA drive changes only on SCL fall.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    byte_in   = {shift_q[ByteW-2:0], sda_s};

    if (bus_start) begin
      state_d  = StDevAddr;
      bitcnt_d = 4'd0;
      oe_d     = 1'b0;
      busy_d   = 1'b1;
    end else if (bus_stop) begin
      state_d  = StIdle;
      bitcnt_d = 4'd0;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        StDevAddr, StSubAddr, StWData: begin
          if (scl_rise) begin
            shift_d  = byte_in;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = 4'd0;
              if (state_q == StDevAddr) begin
                if (byte_in[7:1] == DEV_ADDR[7:1]) begin
                  rw_d    = byte_in[0];
                  state_d = StDevAck;
                end else begin
                  state_d = StIgnore;
                end
              end else if (state_q == StSubAddr) begin
                ptr_d   = byte_in;
                state_d = StSubAck;
              end else begin
                mem_we    = 1'b1;
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                ptr_d     = ptr_q + 8'd1;
                state_d   = StWDataAck;
              end
            end
          end
        end
        StDevAck, StSubAck, StWDataAck: begin
          // bitcnt 0: ACK not yet driven; 1: ACK being held low.
          if (scl_fall) begin
            if (bitcnt_q == 4'd0) begin
              oe_d     = 1'b1;
              bitcnt_d = 4'd1;
            end else begin
              oe_d     = 1'b0;
              bitcnt_d = 4'd0;
              if (state_q == StDevAck && rw_q) begin
                state_d  = StRData;
                shift_d  = {bus_rdata_q[ByteW-2:0], 1'b0};
                oe_d     = ~bus_rdata_q[ByteW-1];
                bitcnt_d = 4'd1;
              end else if (state_q == StDevAck) begin
                state_d = StSubAddr;
              end else begin
                state_d = StWData;
              end
            end
          end
        end
        StRData: begin
          // bitcnt counts bits already placed on the bus.
          if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              oe_d     = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = StRdAck;
            end else begin
              oe_d     = ~shift_q[ByteW-1];
              shift_d  = {shift_q[ByteW-2:0], 1'b0};
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise && bitcnt_q == 4'd0) begin
            if (sda_s == SCCB_ACK) begin
              ptr_d    = ptr_q + 8'd1;
              bitcnt_d = 4'd1;
            end else begin
              state_d = StIgnore;
            end
          end else if (scl_fall && bitcnt_q == 4'd1) begin
            state_d  = StRData;
            shift_d  = {bus_rdata_q[ByteW-2:0], 1'b0};
            oe_d     = ~bus_rdata_q[ByteW-1];
            bitcnt_d = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= StIdle;
      bitcnt_q  <= 4'd0;
      shift_q   <= '0;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Register file: bus write/read port at ptr, unreset for RAM inference.
  always_ff @(posedge iCLK) begin
    if (mem_we) begin
      regfile[ptr_q] <= byte_in;
    end
    bus_rdata_q <= regfile[ptr_q];
  end

  // Host read port; returns the pre-write value on a same-cycle collision.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      host_rdata_q <= '0;
    end else begin
      host_rdata_q <= regfile[host.host_raddr];
    end
  end

  assign host.host_rdata = host_rdata_q;
  assign host.wr_stb     = wr_stb_q;
  assign host.wr_addr    = wr_addr_q;
  assign host.wr_data    = wr_data_q;
  assign host.busy       = busy_q;

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Directed bench: bit-banged SCCB master against the register-file responder.
module tb_sccb_slave_regfile;

  localparam int Q = 8;  // iCLK cycles per quarter of an SCL bit

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  sccb_slave_regfile_if hif ();

  sccb_slave_regfile #(
    .DEV_ADDR    (8'h42),
    .SYNC_STAGES (2)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda),
    .host     (hif)
  );

  always #20 clk = ~clk;

  int chk_cnt  = 0;
  int fail_cnt = 0;
  int stb_cnt  = 0;
  logic [7:0] stb_addr = 8'h00;
  logic [7:0] stb_data = 8'h00;

  always @(posedge clk) begin
    if (hif.wr_stb) begin
      stb_cnt  <= stb_cnt + 1;
      stb_addr <= hif.wr_addr;
      stb_data <= hif.wr_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_low = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    m_low = 1'b1; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic bus_stop();
    m_low = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    m_low = 1'b0; wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b;  wait_q();
    scl = 1'b1;  wait_q(); wait_q();
    scl = 1'b0;  wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    b = sda;      wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(master_ack);
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    hif.host_raddr = a;
    @(negedge clk);
    d = hif.host_rdata;
  endtask

  logic       ack;
  logic [7:0] rd;
  int         stb_base;

  initial begin
    hif.host_raddr = 8'h00;
    repeat (4) @(negedge clk);
    // Reset values observed while reset is held.
    check_eq("rst_host_rdata", 32'(hif.host_rdata), 32'h00);
    check_eq("rst_wr_stb", 32'(hif.wr_stb), 32'h0);
    check_eq("rst_wr_addr", 32'(hif.wr_addr), 32'h00);
    check_eq("rst_wr_data", 32'(hif.wr_data), 32'h00);
    check_eq("rst_busy", 32'(hif.busy), 32'h0);
    check_eq("rst_sda", 32'(sda), 32'h1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single write 0x12 <= 0x80.
    bus_start();
    write_byte(8'h42, ack); check_eq("w1_dev_ack", 32'(ack), 32'h0);
    check_eq("w1_busy", 32'(hif.busy), 32'h1);
    write_byte(8'h12, ack); check_eq("w1_sub_ack", 32'(ack), 32'h0);
    write_byte(8'h80, ack); check_eq("w1_dat_ack", 32'(ack), 32'h0);
    bus_stop();
    check_eq("w1_stb_cnt", 32'(stb_cnt), 32'd1);
    check_eq("w1_wr_addr", 32'(stb_addr), 32'h12);
    check_eq("w1_wr_data", 32'(stb_data), 32'h80);
    check_eq("w1_busy_end", 32'(hif.busy), 32'h0);
    host_read(8'h12, rd); check_eq("w1_host_12", 32'(rd), 32'h80);

    // Burst write wrapping FE -> FF -> 00.
    bus_start();
    write_byte(8'h42, ack); check_eq("w2_dev_ack", 32'(ack), 32'h0);
    write_byte(8'hFE, ack);
    write_byte(8'hA1, ack); check_eq("w2_d0_ack", 32'(ack), 32'h0);
    write_byte(8'hB2, ack);
    write_byte(8'hC3, ack); check_eq("w2_d2_ack", 32'(ack), 32'h0);
    bus_stop();
    check_eq("w2_stb_cnt", 32'(stb_cnt), 32'd4);
    check_eq("w2_wr_addr", 32'(stb_addr), 32'h00);
    host_read(8'hFE, rd); check_eq("w2_host_fe", 32'(rd), 32'hA1);
    host_read(8'hFF, rd); check_eq("w2_host_ff", 32'(rd), 32'hB2);
    host_read(8'h00, rd); check_eq("w2_host_00", 32'(rd), 32'hC3);

    // Preload 0x0A/0x0B, then SCCB two-phase read.
    bus_start();
    write_byte(8'h42, ack); write_byte(8'h0A, ack);
    write_byte(8'h76, ack); write_byte(8'h73, ack);
    bus_stop();
    bus_start();
    write_byte(8'h42, ack); write_byte(8'h0A, ack);
    bus_stop();
    bus_start();
    write_byte(8'h43, ack); check_eq("r1_dev_ack", 32'(ack), 32'h0);
    read_byte(rd, 1'b0); check_eq("r1_byte0", 32'(rd), 32'h76);
    read_byte(rd, 1'b1); check_eq("r1_byte1", 32'(rd), 32'h73);
    bus_stop();
    check_eq("r1_sda_rel", 32'(sda), 32'h1);
    check_eq("r1_busy", 32'(hif.busy), 32'h0);

    // Address mismatch: nothing acknowledged or written; ptr stays at 0x0B.
    stb_base = stb_cnt;
    bus_start();
    write_byte(8'h60, ack); check_eq("m_dev_nack", 32'(ack), 32'h1);
    write_byte(8'h01, ack); check_eq("m_sub_nack", 32'(ack), 32'h1);
    write_byte(8'h55, ack); check_eq("m_dat_nack", 32'(ack), 32'h1);
    bus_stop();
    check_eq("m_no_stb", 32'(stb_cnt - stb_base), 32'd0);
    bus_start();
    write_byte(8'h43, ack);
    read_byte(rd, 1'b1); check_eq("m_ptr_kept", 32'(rd), 32'h73);
    bus_stop();

    // Repeated START: set pointer then read without a STOP.
    bus_start();
    write_byte(8'h42, ack); write_byte(8'h05, ack); write_byte(8'h5A, ack);
    bus_stop();
    stb_base = stb_cnt;
    bus_start();
    write_byte(8'h42, ack); write_byte(8'h05, ack);
    bus_start();
    write_byte(8'h43, ack); check_eq("sr_dev_ack", 32'(ack), 32'h0);
    read_byte(rd, 1'b1); check_eq("sr_byte", 32'(rd), 32'h5A);
    bus_stop();
    check_eq("sr_no_stb", 32'(stb_cnt - stb_base), 32'd0);

    // Reset while the responder drives a 0 (bit7 of 0x5A).
    bus_start();
    write_byte(8'h43, ack);
    check_eq("rr_driving", 32'(sda), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rr_sda_rel", 32'(sda), 32'h1);
    check_eq("rr_busy", 32'(hif.busy), 32'h0);
    repeat (4) @(negedge clk);
    bus_stop();
    bus_start();
    write_byte(8'h43, ack); check_eq("rr_dev_ack", 32'(ack), 32'h0);
    read_byte(rd, 1'b1); check_eq("rr_ptr_zero", 32'(rd), 32'hC3);
    bus_stop();

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
